// File: rtl/game_flow_ctrl.sv
// Game-flow controller: shot/scene collision detect, per-target alive mask, shots, score, level
// and screen FSM. Define GAME_CHEAT_EN to enable the cheat_key level skip.
module game_flow_ctrl #(
  parameter int unsigned NUM_TGT         = 3,
  parameter int unsigned SHOTS_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 4,
  parameter int unsigned SCORE_W         = 13,
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned SHOT_W          = 4,
  parameter int unsigned HIT_SCORE       = 16,
  parameter int unsigned BONUS_PER_SHOT  = 5
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           shot_req,
  input  logic                           boarders_req,
  input  logic                           fortress_req,
  input  logic [NUM_TGT-1:0]             tgt_req,
  input  logic                           shot_done,
  input  logic                           start_key,
  input  logic                           cheat_key,
  output logic                           hit_any,
  output logic                           hit_fortress,
  output logic [NUM_TGT-1:0]             hit_tgt,
  output logic [NUM_TGT-1:0]             tgt_alive,
  output logic [$clog2(NUM_TGT+1)-1:0]   tgts_left,
  output logic [SHOT_W-1:0]              shots_left,
  output logic [SCORE_W-1:0]             score,
  output logic [LEVEL_W-1:0]             level,
  output logic [1:0]                     screen,
  output logic                           game_active,
  output logic                           hit_pulse,
  output logic                           new_level_pulse
);

  localparam int unsigned CntW  = $clog2(NUM_TGT + 1);
  localparam int unsigned CalcW = SCORE_W + 8;

  typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StOver = 2'd2, StWin = 2'd3} screen_e;

  screen_e             state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SHOT_W-1:0]   shots_q, shots_d;
  logic [NUM_TGT-1:0]  alive_q, alive_d;
  logic [CntW-1:0]     tgts_left_q, tgts_left_d;
  logic                active_q, active_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic                flag_q, flag_d;
  logic                nlp_q, nlp_d;

  logic                cheat_rise;
  logic                nat_clear, lvl_clear;
  logic [SHOT_W-1:0]   shots_m1;
  logic [CalcW-1:0]    kill_pts, bonus_pts, score_sum;
  logic [SCORE_W-1:0]  score_sat;

  function automatic logic [CntW-1:0] popcnt(input logic [NUM_TGT-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_TGT; i++) c = c + CntW'(v[i]);
    return c;
  endfunction

  assign hit_tgt      = {NUM_TGT{shot_req}} & tgt_req & alive_q;
  assign hit_fortress = shot_req & fortress_req;
  assign hit_any      = shot_req & (boarders_req | fortress_req | (|(tgt_req & alive_q)));

`ifdef GAME_CHEAT_EN
  logic cheat_q, cheat_d;
  assign cheat_d    = cheat_key;
  assign cheat_rise = (state_q == StPlay) & cheat_key & ~cheat_q;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cheat_q <= 1'b0;
    else         cheat_q <= cheat_d;
  end
`else
  logic unused_cheat_key;
  assign unused_cheat_key = cheat_key;
  assign cheat_rise       = 1'b0;
`endif

  // Natural clear: the last alive targets die this cycle; earns the unused-shot bonus.
  assign nat_clear = (state_q == StPlay) && (alive_q != '0) && ((alive_q & ~hit_tgt) == '0);
  assign lvl_clear = nat_clear | cheat_rise;

  always_comb begin
    shots_m1  = (shots_q == '0) ? '0 : shots_q - SHOT_W'(1);
    kill_pts  = CalcW'(popcnt(hit_tgt)) * CalcW'(HIT_SCORE);
    bonus_pts = nat_clear ? CalcW'(shots_m1) * CalcW'(BONUS_PER_SHOT) : '0;
    score_sum = CalcW'(score_q) + kill_pts + bonus_pts;
    score_sat = (|score_sum[CalcW-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    level_d = level_q;
    shots_d = shots_q;
    alive_d = alive_q;
    nlp_d   = 1'b0;
    case (state_q)
      StPlay: begin
        alive_d = alive_q & ~hit_tgt;
        score_d = score_sat;
        if (lvl_clear) begin
          // A clear takes priority over a coincident shot_done.
          alive_d = '1;
          shots_d = SHOT_W'(SHOTS_PER_LEVEL);
          if (level_q == LEVEL_W'(MAX_LEVEL)) begin
            state_d = StWin;
          end else begin
            level_d = level_q + LEVEL_W'(1);
            nlp_d   = 1'b1;
          end
        end else if (shot_done) begin
          shots_d = shots_m1;
          if (shots_q == SHOT_W'(1)) state_d = StOver;
        end
      end
      default: begin
        if (start_key) begin
          state_d = StPlay;
          score_d = '0;
          level_d = '0;
          alive_d = '1;
          shots_d = SHOT_W'(SHOTS_PER_LEVEL);
        end
      end
    endcase
    tgts_left_d = popcnt(alive_d);
    active_d    = (state_d == StPlay);
  end

  // One hit_pulse per frame: re-armed by startOfFrame.
  always_comb begin
    hit_pulse_d = hit_any & (~flag_q | startOfFrame);
    flag_d      = flag_q;
    if (hit_pulse_d)       flag_d = 1'b1;
    else if (startOfFrame) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      score_q     <= '0;
      level_q     <= '0;
      shots_q     <= '0;
      alive_q     <= '0;
      tgts_left_q <= '0;
      active_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
      flag_q      <= 1'b0;
      nlp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      level_q     <= level_d;
      shots_q     <= shots_d;
      alive_q     <= alive_d;
      tgts_left_q <= tgts_left_d;
      active_q    <= active_d;
      hit_pulse_q <= hit_pulse_d;
      flag_q      <= flag_d;
      nlp_q       <= nlp_d;
    end
  end

  assign tgt_alive       = alive_q;
  assign tgts_left       = tgts_left_q;
  assign shots_left      = shots_q;
  assign score           = score_q;
  assign level           = level_q;
  assign screen          = state_q;
  assign game_active     = active_q;
  assign hit_pulse       = hit_pulse_q;
  assign new_level_pulse = nlp_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: default instance plus a narrow-score instance for saturation.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, shot_req, boarders_req, fortress_req, shot_done, start_key, cheat_key;
  logic [2:0] tgt_req;
  logic       hit_any, hit_fortress, game_active, hit_pulse, nlp;
  logic [2:0] hit_tgt, tgt_alive;
  logic [1:0] tgts_left, screen;
  logic [3:0] shots_left, level;
  logic [12:0] score;

  logic       s_start, s_shot_req;
  logic [2:0] s_tgt_req;
  logic       s_hit_any, s_hit_fortress, s_game_active, s_hit_pulse, s_nlp;
  logic [2:0] s_hit_tgt, s_tgt_alive;
  logic [1:0] s_tgts_left, s_screen;
  logic [3:0] s_shots_left, s_level;
  logic [4:0] s_score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_flow_ctrl u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .shot_req(shot_req),
    .boarders_req(boarders_req), .fortress_req(fortress_req), .tgt_req(tgt_req),
    .shot_done(shot_done), .start_key(start_key), .cheat_key(cheat_key),
    .hit_any(hit_any), .hit_fortress(hit_fortress), .hit_tgt(hit_tgt), .tgt_alive(tgt_alive),
    .tgts_left(tgts_left), .shots_left(shots_left), .score(score), .level(level),
    .screen(screen), .game_active(game_active), .hit_pulse(hit_pulse), .new_level_pulse(nlp)
  );

  game_flow_ctrl #(.SCORE_W(5)) u_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(1'b0), .shot_req(s_shot_req),
    .boarders_req(1'b0), .fortress_req(1'b0), .tgt_req(s_tgt_req),
    .shot_done(1'b0), .start_key(s_start), .cheat_key(1'b0),
    .hit_any(s_hit_any), .hit_fortress(s_hit_fortress), .hit_tgt(s_hit_tgt),
    .tgt_alive(s_tgt_alive), .tgts_left(s_tgts_left), .shots_left(s_shots_left),
    .score(s_score), .level(s_level), .screen(s_screen), .game_active(s_game_active),
    .hit_pulse(s_hit_pulse), .new_level_pulse(s_nlp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kill(input logic [2:0] m);
    shot_req = 1'b1;
    tgt_req  = m;
    tick();
    shot_req = 1'b0;
    tgt_req  = 3'b000;
  endtask

  task automatic shots(input int n);
    for (int i = 0; i < n; i++) begin
      shot_done = 1'b1;
      tick();
      shot_done = 1'b0;
    end
  endtask

  task automatic start_game();
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
  endtask

  initial begin
    int pulses;
    int nlp_cnt;
    resetN = 1'b0; sof = 1'b0; shot_req = 1'b0; boarders_req = 1'b0; fortress_req = 1'b0;
    shot_done = 1'b0; start_key = 1'b0; cheat_key = 1'b0; tgt_req = 3'b000;
    s_start = 1'b0; s_shot_req = 1'b0; s_tgt_req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_screen", screen, 0);
    check("rst_active", game_active, 0);
    check("rst_score", score, 0);
    check("rst_level", level, 0);
    check("rst_shots", shots_left, 0);
    check("rst_alive", tgt_alive, 0);
    check("rst_left", tgts_left, 0);
    check("rst_pulses", {hit_pulse, nlp}, 0);
    resetN = 1'b1;

    start_game();
    check("start_screen", screen, 1);
    check("start_active", game_active, 1);
    check("start_shots", shots_left, 10);
    check("start_alive", tgt_alive, 3'b111);
    check("start_left", tgts_left, 3);
    check("start_score", score, 0);

    shot_req = 1'b1; tgt_req = 3'b001; #1;
    check("comb_hit_tgt0", hit_tgt, 3'b001);
    check("comb_hit_any0", hit_any, 1);
    check("comb_hit_fort0", hit_fortress, 0);
    tick(); shot_req = 1'b0; tgt_req = 3'b000;
    check("kill0_score", score, 16);
    check("kill0_alive", tgt_alive, 3'b110);
    check("kill0_left", tgts_left, 2);

    shot_req = 1'b1; tgt_req = 3'b001; #1;
    check("dead_hit_tgt", hit_tgt, 3'b000);
    check("dead_hit_any", hit_any, 0);
    tick(); shot_req = 1'b0; tgt_req = 3'b000;
    check("rescore", score, 16);

    shot_req = 1'b1; fortress_req = 1'b1; #1;
    check("fort_hit", hit_fortress, 1);
    check("fort_any", hit_any, 1);
    shot_req = 1'b0; fortress_req = 1'b0;

    shot_req = 1'b1; tgt_req = 3'b110; #1;
    check("comb_hit_tgt12", hit_tgt, 3'b110);
    tick(); shot_req = 1'b0; tgt_req = 3'b000;
    check("clear1_score", score, 93);
    check("clear1_level", level, 1);
    check("clear1_nlp", nlp, 1);
    check("clear1_alive", tgt_alive, 3'b111);
    check("clear1_shots", shots_left, 10);
    tick();
    check("nlp_width", nlp, 0);

    shots(9);
    check("shots9_left", shots_left, 1);
    check("shots9_screen", screen, 1);
    shots(1);
    check("shots10_left", shots_left, 0);
    check("over_screen", screen, 2);
    check("over_active", game_active, 0);
    shots(1);
    check("over_shot_ign", shots_left, 0);

    start_key = 1'b1;
    tick();
    check("restart_score", score, 0);
    check("restart_level", level, 0);
    check("restart_screen", screen, 1);
    kill(3'b001);
    start_key = 1'b0;
    check("start_held_ign", score, 16);

    kill(3'b110);
    check("lv1_score", score, 93);
    kill(3'b111);
    kill(3'b111);
    kill(3'b111);
    check("lv4_level", level, 4);
    check("lv4_score", score, 372);
    check("lv4_nlp", nlp, 1);
    shots(9);
    check("lv4_shots", shots_left, 1);
    kill(3'b011);
    check("lv4_kill_score", score, 404);
    shot_done = 1'b1;
    kill(3'b100);
    shot_done = 1'b0;
    check("win_screen", screen, 3);
    check("win_score", score, 420);
    check("win_level", level, 4);
    check("win_nlp", nlp, 0);
    check("win_active", game_active, 0);

    start_game();
    check("replay_screen", screen, 1);
    #2 resetN = 1'b0;
    #1;
    check("async_screen", screen, 0);
    check("async_score", score, 0);
    check("async_active", game_active, 0);
    @(posedge clk); #1 resetN = 1'b1;

    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      sof          = (c % 8 == 0);
      shot_req     = (c < 24);
      boarders_req = (c < 24);
      tick();
      if (hit_pulse) pulses++;
    end
    sof = 1'b0; shot_req = 1'b0; boarders_req = 1'b0;
    check("hit_pulse_count", pulses, 3);

    s_start = 1'b1; tick(); s_start = 1'b0;
    s_shot_req = 1'b1; s_tgt_req = 3'b001; tick();
    check("sat_first", s_score, 16);
    s_tgt_req = 3'b010; tick();
    check("sat_clamp", s_score, 31);
    s_tgt_req = 3'b100; tick();
    s_shot_req = 1'b0; s_tgt_req = 3'b000;
    check("sat_clear_score", s_score, 31);
    check("sat_clear_level", s_level, 1);

`ifdef GAME_CHEAT_EN
    start_game();
    nlp_cnt = 0;
    cheat_key = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (nlp) nlp_cnt++;
    end
    cheat_key = 1'b0;
    check("cheat_level", level, 1);
    check("cheat_nlp_cnt", nlp_cnt, 1);
    check("cheat_no_bonus", score, 0);
`else
    nlp_cnt = 0;
    start_game();
    cheat_key = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (nlp) nlp_cnt++;
    end
    cheat_key = 1'b0;
    check("cheat_ignored_level", level, 0);
    check("cheat_ignored_nlp", nlp_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller for the VGA game: detects shot/scene collisions and tracks per-target alive state, shots, score, level and screen state. It replaces the fixed-count controller with configurable target channels, level count, shot budget and score width. A target can be scored only once per level, and score saturates. Sits between the object drawing-request muxes and the screen, score and level display blocks.

## Interface
- NUM_TGT, 3, number of target channels; all targets must be killed to clear a level
- SHOTS_PER_LEVEL, 10, shot budget per level (≥1, <2^SHOT_W)
- MAX_LEVEL, 4, last level index; levels run 0..MAX_LEVEL
- SCORE_W, 13, score width
- LEVEL_W, 4, level width
- SHOT_W, 4, shots_left width
- HIT_SCORE, 16, points per target kill
- BONUS_PER_SHOT, 5, points per unused shot at level clear
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- shot_req  in  1  shot object drawing request
- boarders_req  in  1  border drawing request
- fortress_req  in  1  fortress drawing request
- tgt_req  in  NUM_TGT  per-target drawing requests
- shot_done  in  1  one-cycle pulse: current shot finished
- start_key  in  1  level-sensitive start request
- cheat_key  in  1  level-skip key, raw
- hit_any  out  1  combinational: shot overlaps border, fortress or any alive target
- hit_fortress  out  1  combinational: shot_req & fortress_req
- hit_tgt  out  NUM_TGT  combinational: shot_req & tgt_req[i] & tgt_alive[i]
- tgt_alive  out  NUM_TGT  registered alive mask
- tgts_left  out  $clog2(NUM_TGT+1)  popcount of tgt_alive
- shots_left  out  SHOT_W  remaining shots
- score  out  SCORE_W  saturating score
- level  out  LEVEL_W  current level
- screen  out  2  0 IDLE, 1 PLAY, 2 OVER, 3 WIN
- game_active  out  1  high while in PLAY
- hit_pulse  out  1  at most one pulse per frame on hit_any
- new_level_pulse  out  1  one-cycle pulse on level advance

## Operation
- IDLE/OVER/WIN: if start_key is high, clear score and level, set tgt_alive to all ones and shots_left to SHOTS_PER_LEVEL, then enter PLAY.
- PLAY, target kill: each channel i with hit_tgt[i] clears tgt_alive[i]. k simultaneous kills add k·HIT_SCORE.
- Level clear: the cycle in which tgt_alive becomes zero.
  - Add bonus (shots_left−1)·BONUS_PER_SHOT, where shots_left is the pre-update value.
  - Reload tgt_alive and shots_left.
  - If level==MAX_LEVEL, go to WIN. Otherwise level+1 and new_level_pulse=1.
- shot_done in PLAY: shots_left−1. If the pre-update shots_left is 1 and the level is not cleared in the same cycle, go to OVER.
- Level clear coincident with shot_done: level clear wins and shot_done is dropped. The last-shot kill wins the level.
- Score arithmetic is done at SCORE_W+8 bits. Results above 2^SCORE_W−1 clamp to all ones.
- hit_pulse fires when hit_any && (!flag || startOfFrame); flag then sets. startOfFrame without a hit clears flag.
- start_key held while in PLAY: ignored.

## Timing
- Reset values:
  - screen 0, game_active 0, score 0, level 0
  - shots_left 0, tgt_alive 0, tgts_left 0
  - hit_pulse 0, new_level_pulse 0, flag 0
  - cheat edge register 0
- All outputs except hit_any, hit_fortress and hit_tgt are registered: one-cycle latency from the causing input.
- Reset asserted mid-game returns to IDLE immediately and asynchronously.
- hit_pulse and new_level_pulse are exactly one cycle wide.

## Configuration
- GAME_CHEAT_EN defined:
  - A rising edge of cheat_key in PLAY forces a level clear without bonus.
  - At MAX_LEVEL it goes to WIN; otherwise level+1, new_level_pulse, and reload.
  - A coincident natural level clear is treated as a single clear.
- GAME_CHEAT_EN undefined: cheat_key is ignored and no edge register is built; the port remains.

## Test plan
- Reset, then start_key for one cycle -> next cycle screen=1, game_active=1, shots_left=10, tgt_alive=3'b111, score=0.
- Kill tgt 0, then tgt 0 again, then tgts 1 and 2 in the same cycle with shots_left=10 -> score 16, 16 (no rescore), then 16+32+45=93; level=1; new_level_pulse for 1 cycle.
- Ten shot_done pulses with no kills -> shots_left reaches 0 and screen=2 on the cycle after the tenth.
- Final target kill coincident with the last shot_done at level 4 -> screen=3, not 2.
- hit_any held 3 frames -> exactly 3 hit_pulse cycles, one per startOfFrame period.
- With GAME_CHEAT_EN, cheat_key held 100 cycles at level 0 -> level=1 once. SCORE_W=5, HIT_SCORE=16, two kills -> score=31 (saturated).
